rc_pwm_pulse_decoder: RTL and testbench

//   Receive side of the RC-servo PWM interface: measures the high time of an incoming
//   1-2 ms servo pulse (20 ms frame) and converts it to a position code.

---
 rtl/rc_pwm_pulse_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_rc_pwm_pulse_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc_pwm_pulse_decoder.sv
// -----------------------------------------------------------------------------
// rc_pwm_pulse_decoder
//   Receive side of an RC-servo PWM link. Measures the high time of an incoming
//   1-2 ms servo pulse (20 ms frame) in whole microseconds and converts it to a
//   position code using counters only (no divider). Malformed pulses raise a
//   one-cycle error strobe; a missing rising edge for TIMEOUT_US raises a level
//   timeout flag that clears on the next accepted pulse. One instance per axis.
//
//   Optional build macro:
//     RC_PWM_GLITCH_FILTER_EN - inserts a 3-sample majority filter between the
//     synchronizer and the edge detector; single-cycle spikes are ignored and
//     every event latency grows by 2 cycles.
//
// Ports
//   clk_i        in   1      system clock
//   reset_i      in   1      asynchronous, active-high reset
//   pwm_async_i  in   1      asynchronous servo PWM input
//   position_o   out  POS_W  last accepted position; held between updates
//   width_us_o   out  16     raw width (us) of the last accepted pulse
//   valid_o      out  1      1-cycle strobe: position_o/width_us_o updated
//   error_o      out  1      1-cycle strobe: pulse rejected (too short/long)
//   timeout_o    out  1      level: no rising edge within TIMEOUT_US
// -----------------------------------------------------------------------------
module rc_pwm_pulse_decoder #(
  parameter int TICK_DIV   = 50,
  parameter int MIN_US     = 1000,
  parameter int MAX_US     = 2000,
  parameter int STEP_US    = 4,
  parameter int TOL_US     = 50,
  parameter int TIMEOUT_US = 25000,
  parameter int POS_W      = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pwm_async_i,
  output logic [POS_W-1:0] position_o,
  output logic [15:0]      width_us_o,
  output logic             valid_o,
  output logic             error_o,
  output logic             timeout_o
);

  localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W  = $clog2(STEP_US + 1);
  localparam int FRAME_W = $clog2(TIMEOUT_US + 1);

  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0]  STEP_END   = STEP_W'(STEP_US - 1);
  localparam logic [POS_W-1:0]   POS_FULL   = POS_W'((MAX_US - MIN_US) / STEP_US);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(TIMEOUT_US);
  localparam logic [FRAME_W-1:0] FRAME_PRE  = FRAME_W'(TIMEOUT_US - 1);
  localparam logic [15:0]        W_MIN      = 16'(MIN_US);
  localparam logic [15:0]        W_LO       = 16'(MIN_US - TOL_US);
  localparam logic [15:0]        W_HI       = 16'(MAX_US + TOL_US);

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc_width(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [POS_W-1:0] sat_inc_pos(input logic [POS_W-1:0] v);
    return (v >= POS_FULL) ? POS_FULL : v + POS_W'(1);
  endfunction

  // Synchronizer and edge-detect flops reset to 1: after reset the line is
  // treated as high, so a pulse already in progress never produces a rise and
  // the FSM only leaves ARM once a genuine low has travelled through.
  logic sync_p0, sync_p1;
  logic lvl_src;

  // ---- stage 0/1: two-flop synchronizer ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= pwm_async_i;
      sync_p1 <= sync_p0;
    end
  end

`ifdef RC_PWM_GLITCH_FILTER_EN
  logic hist_p2, hist_p3, filt_p3;

  // ---- filter stage: majority of the current and two previous samples ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hist_p2 <= 1'b1;
      hist_p3 <= 1'b1;
      filt_p3 <= 1'b1;
    end else begin
      hist_p2 <= sync_p1;
      hist_p3 <= hist_p2;
      filt_p3 <= (sync_p1 & hist_p2) | (sync_p1 & hist_p3) | (hist_p2 & hist_p3);
    end
  end

  assign lvl_src = filt_p3;
`else
  assign lvl_src = sync_p1;
`endif

  logic lvl_p2, rise_p2, fall_p2;

  // ---- edge stage: registered rise/fall events aligned with lvl_p2 ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lvl_p2  <= 1'b1;
      rise_p2 <= 1'b0;
      fall_p2 <= 1'b0;
    end else begin
      lvl_p2  <= lvl_src;
      rise_p2 <= lvl_src & ~lvl_p2;
      fall_p2 <= ~lvl_src & lvl_p2;
    end
  end

  logic [PRE_W-1:0]   pre_q;
  logic [FRAME_W-1:0] frame_q;
  logic [15:0]        width_q, width_nxt;
  logic [STEP_W-1:0]  step_q, step_nxt;
  logic [POS_W-1:0]   pos_q, pos_nxt;
  state_t             state_q;
  logic               tick, too_long, accept;

  // Next-value view of the measurement counters: a tick landing on the same
  // cycle as the fall still counts, so a pulse of N*TICK_DIV cycles reads N us.
  always_comb begin
    tick      = (pre_q == PRE_LAST);
    width_nxt = tick ? sat_inc_width(width_q) : width_q;
    step_nxt  = step_q;
    pos_nxt   = pos_q;
    if (tick && (width_q >= W_MIN)) begin
      if (step_q == STEP_END) begin
        step_nxt = '0;
        pos_nxt  = sat_inc_pos(pos_q);
      end else begin
        step_nxt = step_q + STEP_W'(1);
      end
    end
    too_long = (state_q == S_HIGH) && (width_nxt > W_HI);
    accept   = (state_q == S_HIGH) && !too_long && fall_p2 && (width_nxt >= W_LO);
  end

  // ---- tick stage: 1 us prescaler and rise-to-rise frame counter ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pre_q     <= '0;
      frame_q   <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (rise_p2 || tick) pre_q <= '0;
      else                 pre_q <= pre_q + PRE_W'(1);

      if (rise_p2)                           frame_q <= '0;
      else if (tick && frame_q != FRAME_LAST) frame_q <= frame_q + FRAME_W'(1);

      // A timeout reached on the same cycle as a rise still sets the flag.
      if (tick && frame_q == FRAME_PRE) timeout_o <= 1'b1;
      else if (accept)                  timeout_o <= 1'b0;
    end
  end

  // ---- measurement FSM and registered outputs ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_ARM;
      width_q    <= '0;
      step_q     <= '0;
      pos_q      <= '0;
      position_o <= '0;
      width_us_o <= '0;
      valid_o    <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      error_o <= 1'b0;
      case (state_q)
        S_ARM: begin
          if (!lvl_p2) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (rise_p2) begin
            state_q <= S_HIGH;
            width_q <= '0;
            step_q  <= '0;
            pos_q   <= '0;
          end
        end
        S_HIGH: begin
          width_q <= width_nxt;
          step_q  <= step_nxt;
          pos_q   <= pos_nxt;
          if (too_long) begin
            // Abort while still high; ARM waits for the line to drop.
            error_o <= 1'b1;
            state_q <= S_ARM;
          end else if (fall_p2) begin
            if (accept) begin
              valid_o    <= 1'b1;
              position_o <= pos_nxt;
              width_us_o <= width_nxt;
            end else begin
              error_o <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_pwm_pulse_decoder.sv
// -----------------------------------------------------------------------------
// tb_rc_pwm_pulse_decoder
//   Scoreboard bench for rc_pwm_pulse_decoder. Stimulus is described in
//   microseconds of high/low time; for each pulse the expected strobe (kind,
//   cycle, position, width, timeout level) is derived from the pulse width
//   rules and pushed into a queue. A monitor pops and compares on every strobe.
// -----------------------------------------------------------------------------
module tb_rc_pwm_pulse_decoder;

  localparam int T       = 2;
  localparam int MIN     = 1000;
  localparam int MAX     = 2000;
  localparam int STEP    = 4;
  localparam int TOL     = 50;
  localparam int TMO     = 3000;
  localparam int FULL    = (MAX - MIN) / STEP;
`ifdef RC_PWM_GLITCH_FILTER_EN
  localparam int LAT     = 6;
`else
  localparam int LAT     = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        pwm = 1'b0;
  logic [7:0]  position_o;
  logic [15:0] width_us_o;
  logic        valid_o, error_o, timeout_o;

  rc_pwm_pulse_decoder #(
    .TICK_DIV(T), .MIN_US(MIN), .MAX_US(MAX), .STEP_US(STEP),
    .TOL_US(TOL), .TIMEOUT_US(TMO), .POS_W(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .pwm_async_i(pwm),
    .position_o(position_o), .width_us_o(width_us_o),
    .valid_o(valid_o), .error_o(error_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int cyc;
    int pos;
    int width;
    bit to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int last_pos  = 0;
  int last_w    = 0;
  bit to_flag   = 0;
  int last_rise = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_pos(input int h);
    if (h <= MIN) return 0;
    if (h >= MAX) return FULL;
    return (h - MIN) / STEP;
  endfunction

  task automatic hold(input int us);
    repeat (us * T) @(posedge clk);
    #1;
  endtask

  task automatic note_rise(input int r);
    if (r - last_rise >= TMO * T) to_flag = 1;
    last_rise = r;
  endtask

  task automatic pulse(input int h, input int l);
    exp_t e;
    int r;
    pwm = 1'b1;
    r = cyc;
    note_rise(r);
    e.to = to_flag;
    if (h > MAX + TOL) begin
      e.is_err = 1; e.cyc = r + LAT + (MAX + TOL + 1) * T;
      e.pos = last_pos; e.width = last_w;
    end else if (h < MIN - TOL) begin
      e.is_err = 1; e.cyc = r + h * T + LAT;
      e.pos = last_pos; e.width = last_w;
    end else begin
      e.is_err = 0; e.cyc = r + h * T + LAT;
      e.pos = ref_pos(h); e.width = h; e.to = 0;
      last_pos = e.pos; last_w = h; to_flag = 0;
    end
    exp_q.push_back(e);
    hold(h);
    pwm = 1'b0;
    hold(l);
  endtask

  task automatic spike(input int l);
    exp_t e;
    int r;
    pwm = 1'b1;
    r = cyc;
    @(posedge clk); #1;
    pwm = 1'b0;
`ifndef RC_PWM_GLITCH_FILTER_EN
    note_rise(r);
    e.is_err = 1; e.cyc = r + 1 + LAT; e.pos = last_pos; e.width = last_w; e.to = to_flag;
    exp_q.push_back(e);
`endif
    hold(l);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_position"}, int'(position_o), 0);
    check_eq({tag, "_width"},    int'(width_us_o), 0);
    check_eq({tag, "_valid"},    int'(valid_o), 0);
    check_eq({tag, "_error"},    int'(error_o), 0);
    check_eq({tag, "_timeout"},  int'(timeout_o), 0);
  endtask

  task automatic reset_model();
    last_pos = 0; last_w = 0; to_flag = 0; last_rise = cyc;
  endtask

  function automatic int ref_timeout();
    return (to_flag || (cyc - last_rise >= TMO * T)) ? 1 : 0;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset_i && (valid_o || error_o)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", int'({valid_o, error_o}), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("strobe_kind(2=valid,1=error)", int'({valid_o, error_o}), mon_e.is_err ? 1 : 2);
        check_eq("strobe_cycle", cyc, mon_e.cyc);
        check_eq("position", int'(position_o), mon_e.pos);
        check_eq("width_us", int'(width_us_o), mon_e.width);
        check_eq("timeout_at_strobe", int'(timeout_o), int'(mon_e.to));
      end
    end
  end

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    pwm = 1'b0;
    reset_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_i = 1'b0;
    reset_model();
    hold(20);

    // Nominal and range-clamp pulses
    pulse(1500, 60);
    pulse(1000, 60);
    pulse(2000, 60);
    pulse(980, 60);
    pulse(2040, 60);

    // Rejects: too short (position held), too long (abort), then recovery
    pulse(900, 60);
    pulse(2600, 60);
    pulse(1500, 60);

    // Tolerance boundaries
    pulse(949, 60);
    pulse(2050, 60);

    // Frame loss: flag rises only after TMO without a rise,
    // survives an error pulse, clears on the next accepted pulse
    pulse(1500, 0);
    hold(900);
    check_eq("timeout_before_limit", int'(timeout_o), ref_timeout());
    hold(2000);
    check_eq("timeout_after_limit", int'(timeout_o), ref_timeout());
    pulse(900, 60);
    check_eq("timeout_held_after_error", int'(timeout_o), ref_timeout());
    pulse(1200, 60);
    check_eq("timeout_cleared_by_valid", int'(timeout_o), ref_timeout());

    // Reset in the middle of a pulse, line still high at release
    pwm = 1'b1;
    hold(300);
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midpulse_reset");
    reset_i = 1'b0;
    reset_model();
    hold(300);
    pwm = 1'b0;
    hold(60);
    pulse(1500, 60);

    // Single-cycle spike
    spike(60);
    pulse(1500, 60);

    // Randomized widths across and beyond the accepted window
    for (int i = 0; i < 3; i++) begin
      int h, l;
      h = int'($urandom_range(2200, 800));
      l = int'($urandom_range(150, 60));
      pulse(h, l);
    end

    hold(100);
    check_eq("pending_expectations", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
